mul_unit: RTL
=============

// Module: mul_unit
// PURPOSE
//  Iterative multi-cycle multiplier for the ARM multicycle datapath.
//  It sits beside the ALU, downstream of the decoder: it consumes ALUControl
//  codes 3'b101 (MUL), 3'b110 (SMUL) and 3'b111 (UMUL), plus both source operands.
//  It returns a 2*WIDTH-bit product with N/Z flags after a fixed latency.
//  The main FSM holds its execute state while Busy=1.
// PARAMETERS
//  WIDTH  32  operand width in bits; product is 2*WIDTH bits
// PORTS
//  clk       in   1        clock; all state updates on rising edge
//  reset     in   1        synchronous, active-high reset
//  Start     in   1        request; sampled only in IDLE or DONE
//  MulOp     in   3        ALUControl code: 101 MUL, 110 SMUL, 111 UMUL
//  SrcA      in   WIDTH    multiplicand (Rn)
//  SrcB      in   WIDTH    multiplier (Rm)
//  Busy      out  1        high in CALC and FIX
//  Done      out  1        one-cycle pulse; Result*/Flags valid
//  ResultLo  out  WIDTH    product bits [WIDTH-1:0]
//  ResultHi  out  WIDTH    product bits [2W-1:W]; 0 for MUL
//  MulFlags  out  2        {N,Z} of the result
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset, including mid-operation:
//   - state=IDLE; Busy, Done, ResultLo, ResultHi, MulFlags all 0;
//     counter and internal registers cleared.
//   - No partial result survives reset.
//  States: IDLE, CALC, FIX, DONE.
//   - IDLE: Start & valid MulOp -> CALC. Latch |SrcA|, |SrcB| (magnitudes
//     for SMUL, raw values otherwise), Neg = SrcA[W-1]^SrcB[W-1] (SMUL only),
//     and Op. Clear accumulator and count.
//   - CALC: one radix-2 shift-add step per cycle, LSB of multiplier first.
//     Exactly WIDTH steps, then -> FIX.
//   - FIX: if Neg, 2*WIDTH-bit two's-complement negate. Load ResultLo/Hi
//     and MulFlags -> DONE.
//   - DONE: Done=1 for exactly this cycle. Next: Start & valid MulOp -> CALC
//     (back-to-back allowed); otherwise -> IDLE.
//  Latency: Start high in cycle 0 -> Done high in cycle WIDTH+2 (34 at default).
//   Throughput is one op per WIDTH+2 cycles.
//  Result registers hold their value until the next FIX or reset.
//  Start in CALC/FIX is ignored: no restart, no queueing.
//  Start with MulOp not in {101,110,111} is ignored; state stays IDLE or DONE.
//  Operands are latched on accept; SrcA/SrcB/MulOp changes while Busy have no
//   effect.
//  Width rules:
//   - MUL: low WIDTH bits of the unsigned product; ResultHi forced to 0.
//     Sign-agnostic, so low bits match the signed product.
//   - UMUL: full unsigned 2W product.
//   - SMUL: full signed 2W product. Magnitude of the most-negative value
//     (1<<(W-1)) is handled as unsigned.
//   - Accumulator is 2*WIDTH+1 bits internally; no overflow is possible.
//  Flags:
//   - MUL: N=ResultLo[W-1], Z=(ResultLo==0).
//   - SMUL/UMUL: N=ResultHi[W-1], Z=({Hi,Lo}==0).
//   - C/V are not produced; the decoder's FlagW masks them.
//  Busy is combinational from state; Done is registered.
// TESTING
//  1 MUL 7*6 -> Done at cycle 34; Lo=0x0000002A, Hi=0, Flags=00.
//  2 SMUL 0xFFFFFFFD*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, N=1 Z=0.
//    Also SMUL 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
//  3 UMUL 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, N=1.
//    Also MUL 0*0x1234 -> Z=1.
//  4 Start re-pulsed with new operands in CALC cycle 10 -> ignored.
//    First result unchanged; back-to-back Start in DONE -> next Done 34 cycles later.
//  5 reset asserted in CALC cycle 15 -> next cycle IDLE, all outputs 0.
//    Fresh op then completes normally.
//  6 Start with MulOp=3'b000 -> Busy stays 0, no Done.
//    Randomized 1k ops checked against a $signed/unsigned reference model.

Source files
------------

// File: rtl/mul_unit.sv
`timescale 1ns/1ps
// mul_unit: iterative radix-2 shift-add multiplier for the multicycle datapath.
// Accepts MUL (101), SMUL (110) and UMUL (111). The result appears WIDTH+2
// cycles after the accepted Start, together with a one-cycle Done pulse.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   Start, MulOp        request and ALUControl code (sampled in IDLE/DONE)
//   SrcA, SrcB          multiplicand / multiplier
//   Busy                high while computing (CALC, FIX), decoded from state
//   Done                registered one-cycle completion pulse
//   ResultLo, ResultHi  product halves (ResultHi is 0 for MUL)
//   MulFlags            {N,Z} of the result
module mul_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MulOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + 1;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SMUL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             lo_only_q, lo_only_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [1:0]       flags_q, flags_d;

    logic             op_valid;
    logic             is_smul;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   upper_sum;
    logic [PW-1:0]    prod, fixed;

    // Request decode and operand magnitudes (SMUL only takes absolute values;
    // the most-negative value negates to itself, which is its correct unsigned magnitude).
    assign op_valid = MulOp[2] & (MulOp[1] | MulOp[0]);
    assign is_smul  = (MulOp == OP_SMUL);
    assign mag_a    = (is_smul && SrcA[WIDTH-1]) ? WIDTH'(~SrcA + WIDTH'(1)) : SrcA;
    assign mag_b    = (is_smul && SrcB[WIDTH-1]) ? WIDTH'(~SrcB + WIDTH'(1)) : SrcB;

    // One shift-add step: the multiplier lives in the low half of the
    // accumulator, so acc_q[0] is the current multiplier bit.
    assign upper_sum = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);

    // Final sign correction of the 2W-bit magnitude product.
    assign prod  = acc_q[PW-1:0];
    assign fixed = neg_q ? PW'(~prod + PW'(1)) : prod;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        lo_only_d = lo_only_q;
        done_d    = 1'b0;
        lo_d      = lo_q;
        hi_d      = hi_q;
        flags_d   = flags_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start && op_valid) begin
                    state_d   = S_CALC;
                    mcand_d   = mag_a;
                    acc_d     = {{(WIDTH + 1){1'b0}}, mag_b};
                    cnt_d     = '0;
                    neg_d     = is_smul & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    lo_only_d = (MulOp == OP_MUL);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                lo_d    = fixed[WIDTH-1:0];
                if (lo_only_q) begin
                    hi_d    = '0;
                    flags_d = {fixed[WIDTH-1], (fixed[WIDTH-1:0] == '0)};
                end else begin
                    hi_d    = fixed[PW-1:WIDTH];
                    flags_d = {fixed[PW-1], (fixed == '0)};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            lo_only_q <= 1'b0;
            done_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            lo_only_q <= lo_only_d;
            done_q    <= done_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            flags_q   <= flags_d;
        end
    end

    assign Busy     = (state_q == S_CALC) || (state_q == S_FIX);
    assign Done     = done_q;
    assign ResultLo = lo_q;
    assign ResultHi = hi_q;
    assign MulFlags = flags_q;

endmodule
